// File: rtl/conv_pipe_param.sv
// conv_pipe_param: backpressured DIMxDIM convolution engine, three register stages, double-buffered kernel.
// Define CONV_STATS_EN to add the beat_cnt / sat_cnt output counters.
module conv_pipe_param #(
  parameter int DIM   = 3,
  parameter int CH    = 3,
  parameter int PW    = 8,
  parameter int KW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIM*DIM*CH*PW-1:0] s_data,
  input  logic                     s_vld,
  output logic                     s_rdy,
  input  logic [1:0]               mode,
  output logic [CH*PW-1:0]         m_data,
  output logic                     m_vld,
  input  logic                     m_rdy,
`ifdef CONV_STATS_EN
  output logic [31:0]              beat_cnt,
  output logic [31:0]              sat_cnt,
`endif
  input  logic                     k_wr,
  input  logic [5:0]               k_addr,
  input  logic [KW-1:0]            k_data,
  input  logic                     k_commit
);

  localparam int NK      = DIM * DIM;
  localparam int CI      = NK / 2;
  localparam int PRW     = PW + KW + 1;
  localparam int SW      = PRW + $clog2(NK);
  localparam int EW      = SW + 1;
  localparam int RND     = (2 ** SHIFT) / 2;
  localparam int ID_COEF = 2 ** SHIFT;

  localparam logic [KW-1:0]        ID_K     = KW'(ID_COEF);
  localparam logic [1:0]           MODE_BYP = 2'd0;
  localparam logic [1:0]           MODE_ABS = 2'd2;
  localparam logic signed [EW-1:0] MAX_PIX  = {{(EW - PW){1'b0}}, {PW{1'b1}}};

  if (DIM < 1 || DIM > 7 || (DIM % 2) == 0) begin : g_bad_dim
    $error("conv_pipe_param: DIM must be odd and within 1..7");
  end
  if (SHIFT < 0 || SHIFT > 15 || ID_COEF > (2 ** (KW - 1)) - 1) begin : g_bad_shift
    $error("conv_pipe_param: identity coefficient 1<<SHIFT does not fit in KW bits");
  end

  // ---------------------------------------------------------------- kernels
  logic signed [KW-1:0] shadow_reg [NK];
  logic signed [KW-1:0] active_reg [NK];

  // A same-cycle write is forwarded into the commit so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        shadow_reg[k] <= (k == CI) ? ID_K : '0;
        active_reg[k] <= (k == CI) ? ID_K : '0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (k_wr && int'(k_addr) == k) begin
          shadow_reg[k] <= k_data;
        end
        if (k_commit) begin
          active_reg[k] <= (k_wr && int'(k_addr) == k) ? k_data : shadow_reg[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------- control
  logic ce;
  logic vld1_reg, vld2_reg, m_vld_reg;

  assign ce    = !m_vld_reg || m_rdy;
  assign s_rdy = ce;
  assign m_vld = m_vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_reg  <= 1'b0;
      vld2_reg  <= 1'b0;
      m_vld_reg <= 1'b0;
    end else if (ce) begin
      vld1_reg  <= s_vld;
      vld2_reg  <= vld1_reg;
      m_vld_reg <= vld2_reg;
    end
  end

  // Mode and centre pixel ride along with the beat for bypass and abs handling.
  logic [1:0]       mode1_reg, mode2_reg;
  logic [CH*PW-1:0] ctr1_reg, ctr2_reg;

  always_ff @(posedge clk) begin
    if (ce && s_vld) begin
      mode1_reg <= mode;
      ctr1_reg  <= s_data[CI*CH*PW +: CH*PW];
    end
    if (ce && vld1_reg) begin
      mode2_reg <= mode1_reg;
      ctr2_reg  <= ctr1_reg;
    end
  end

`ifdef CONV_STATS_EN
  logic [CH-1:0] clip_vec;
`endif

  // ---------------------------------------------------------------- datapath
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [PRW-1:0] prod_reg [NK];
      logic signed [SW-1:0]  sum_reg;
      logic signed [SW-1:0]  sum_next;
      logic signed [EW-1:0]  rnd_sum;
      logic signed [EW-1:0]  res_wide;
      logic [PW-1:0]         pix_next;
      logic [PW-1:0]         pix_reg;

      always_comb begin
        sum_next = '0;
        for (int k = 0; k < NK; k++) begin
          sum_next = sum_next + SW'(prod_reg[k]);
        end
      end

      always_ff @(posedge clk) begin
        if (ce && s_vld) begin
          for (int k = 0; k < NK; k++) begin
            prod_reg[k] <= PRW'($signed({1'b0, s_data[(k*CH+gi)*PW +: PW]})) * PRW'(active_reg[k]);
          end
        end
        if (ce && vld1_reg) begin
          sum_reg <= sum_next;
        end
      end

      // Round half up, then arithmetic shift; abs and clamp act on the shifted value.
      always_comb begin
        rnd_sum  = EW'(sum_reg) + EW'(RND);
        res_wide = rnd_sum >>> SHIFT;
        if (mode2_reg == MODE_ABS && res_wide < 0) begin
          res_wide = -res_wide;
        end
        if (mode2_reg == MODE_BYP) begin
          pix_next = ctr2_reg[gi*PW +: PW];
        end else if (res_wide < 0) begin
          pix_next = '0;
        end else if (res_wide > MAX_PIX) begin
          pix_next = '1;
        end else begin
          pix_next = res_wide[PW-1:0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pix_reg <= '0;
        end else if (ce && vld2_reg) begin
          pix_reg <= pix_next;
        end
      end

      assign m_data[gi*PW +: PW] = pix_reg;

`ifdef CONV_STATS_EN
      assign clip_vec[gi] = (mode2_reg != MODE_BYP) && (res_wide < 0 || res_wide > MAX_PIX);
`endif
    end
  endgenerate

  // ---------------------------------------------------------------- statistics
`ifdef CONV_STATS_EN
  logic        sat_reg;
  logic [31:0] beat_cnt_reg, sat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_reg      <= 1'b0;
      beat_cnt_reg <= '0;
      sat_cnt_reg  <= '0;
    end else begin
      if (ce && vld2_reg) begin
        sat_reg <= |clip_vec;
      end
      // Count at the output handshake so a stalled beat is counted once.
      if (m_vld_reg && m_rdy) begin
        if (beat_cnt_reg != '1) begin
          beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end
        if (sat_reg && sat_cnt_reg != '1) begin
          sat_cnt_reg <= sat_cnt_reg + 32'd1;
        end
      end
    end
  end

  assign beat_cnt = beat_cnt_reg;
  assign sat_cnt  = sat_cnt_reg;
`endif

endmodule
